// File: rtl/rgb2gray_ctrl_pkg.sv
// Shared ISP constants for the RGB565-to-luma stage: coefficients, field
// positions and widths.
package rgb2gray_ctrl_pkg;

    localparam int GRAY_W = 8;
    localparam int PROD_W = 16;

    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [GRAY_W-1:0] r;
        logic [GRAY_W-1:0] g;
        logic [GRAY_W-1:0] b;
    } rgb888_t;

endpackage

// File: rtl/rgb565_expand.sv
// Combinational RGB565 to 8-bit-per-channel expansion by MSB replication,
// so full-scale 5/6-bit codes map exactly to 255.
module rgb565_expand
    import rgb2gray_ctrl_pkg::*;
(
    input  logic [15:0] rgb565_i,
    output rgb888_t     rgb888_o
);

    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;

    assign r5 = rgb565_i[R_MSB:R_LSB];
    assign g6 = rgb565_i[G_MSB:G_LSB];
    assign b5 = rgb565_i[B_MSB:B_LSB];

    assign rgb888_o.r = {r5, r5[4:2]};
    assign rgb888_o.g = {g6, g6[5:4]};
    assign rgb888_o.b = {b5, b5[4:2]};

endmodule

// File: rtl/rgb2gray_ctrl.sv
// RGB565 to 8-bit luma, fixed 3-cycle pipeline. Define RGB2GRAY_FRAME_MARK_EN
// to build the position counters that drive po_sof/po_eol.
module rgb2gray_ctrl
    import rgb2gray_ctrl_pkg::*;
#(
    parameter logic [9:0] CNT_COL_MAX = 10'd99,
    parameter logic [9:0] CNT_ROW_MAX = 10'd99
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pi_vsync,
    input  logic              pi_flag,
    input  logic [15:0]       pi_data,
    output logic [GRAY_W-1:0] po_data,
    output logic              po_flag,
    output logic              po_sof,
    output logic              po_eol
);

    // Flags are plain valid strobes with no ready: each stage captures its
    // data only when the incoming flag is high and otherwise holds it.
    rgb888_t           px8;
    rgb888_t           rgb_q;
    logic              v1_q, v2_q, flag_q;
    logic [PROD_W-1:0] pr_q, pg_q, pb_q;
    logic [PROD_W-1:0] pr_d, pg_d, pb_d, sum_d;
    logic [GRAY_W-1:0] data_q;

    rgb565_expand u_expand (
        .rgb565_i (pi_data),
        .rgb888_o (px8)
    );

    assign pr_d  = {8'd0, COEF_R} * {8'd0, rgb_q.r};
    assign pg_d  = {8'd0, COEF_G} * {8'd0, rgb_q.g};
    assign pb_d  = {8'd0, COEF_B} * {8'd0, rgb_q.b};
    assign sum_d = pr_q + pg_q + pb_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rgb_q  <= '0;
            v1_q   <= 1'b0;
            pr_q   <= '0;
            pg_q   <= '0;
            pb_q   <= '0;
            v2_q   <= 1'b0;
            data_q <= '0;
            flag_q <= 1'b0;
        end else begin
            v1_q   <= pi_flag;
            v2_q   <= v1_q;
            flag_q <= v2_q;
            if (pi_flag) rgb_q <= px8;
            if (v1_q) begin
                pr_q <= pr_d;
                pg_q <= pg_d;
                pb_q <= pb_d;
            end
            // Coefficients sum to 256, so the top byte is truncated luma.
            if (v2_q) data_q <= sum_d[15:8];
        end
    end

    assign po_data = data_q;
    assign po_flag = flag_q;

`ifdef RGB2GRAY_FRAME_MARK_EN
    logic [9:0] col_q, row_q, col_d, row_d, col_eff, row_eff;
    logic       sof1_q, eol1_q, sof2_q, eol2_q, sof_q, eol_q;

    // A vsync pixel is treated as (0,0) before the normal increment.
    always_comb begin
        col_eff = pi_vsync ? 10'd0 : col_q;
        row_eff = pi_vsync ? 10'd0 : row_q;
        col_d   = col_eff;
        row_d   = row_eff;
        if (pi_flag) begin
            if (col_eff == CNT_COL_MAX) begin
                col_d = 10'd0;
                row_d = (row_eff == CNT_ROW_MAX) ? 10'd0 : row_eff + 10'd1;
            end else begin
                col_d = col_eff + 10'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            col_q  <= '0;
            row_q  <= '0;
            sof1_q <= 1'b0;
            eol1_q <= 1'b0;
            sof2_q <= 1'b0;
            eol2_q <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            sof1_q <= pi_flag && (col_eff == 10'd0) && (row_eff == 10'd0);
            eol1_q <= pi_flag && (col_eff == CNT_COL_MAX);
            sof2_q <= v1_q && sof1_q;
            eol2_q <= v1_q && eol1_q;
            sof_q  <= v2_q && sof2_q;
            eol_q  <= v2_q && eol2_q;
        end
    end

    assign po_sof = sof_q;
    assign po_eol = eol_q;
`else
    logic unused_vsync;
    assign unused_vsync = pi_vsync;
    assign po_sof       = 1'b0;
    assign po_eol       = 1'b0;
`endif

endmodule

// File: doc/rgb2gray_ctrl.md
# rgb2gray_ctrl

- Converts the camera's RGB565 pixel stream into 8-bit luma (grayscale) with a fixed 3-cycle pipeline.
- Sits directly upstream of the Sobel edge stage: `po_data`/`po_flag` feed its 8-bit `pi_data`/`pi_flag` inputs unchanged.
- Optionally tracks the pixel position so downstream stages and debug logic get start-of-frame and end-of-line markers.

## Interface
Parameters:
- CNT_COL_MAX, 10'd99: last column index (frame width − 1).
- CNT_ROW_MAX, 10'd99: last row index (frame height − 1).

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  pixel clock; all state updates on its rising edge.
- sys_rst  in  1  synchronous active-high reset.
- pi_vsync  in  1  one-cycle frame-start pulse; resynchronises the position counters.
- pi_flag  in  1  pixel valid; `pi_data` is sampled when high.
- pi_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- po_data  out  8  gray value Y.
- po_flag  out  1  `po_data` valid, one cycle per input pixel.
- po_sof  out  1  high with the `po_flag` of pixel (row 0, col 0).
- po_eol  out  1  high with the `po_flag` of every pixel at col CNT_COL_MAX.

## Operation
Stage 1, expand:
- R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}; registered when `pi_flag` is high.
- v1<=pi_flag.

Stage 2, multiply:
- pr=77·R8, pg=150·G8, pb=29·B8, each 16 bits unsigned; registered when v1 is high.
- v2<=v1.

Stage 3, sum:
- sum=pr+pg+pb, 16 bits; no overflow is possible because the coefficients total 256.
- po_data<=sum[15:8], registered when v2 is high; this is truncation, not rounding.
- po_flag<=v2.

General rules:
- Data registers hold their value while their valid bit is low; only the flags clear.
- No back-pressure exists. The block accepts one pixel per cycle, indefinitely.

Position counters (built only with the Configuration macro):
- cnt_col increments on `pi_flag` and wraps from CNT_COL_MAX to 0.
- cnt_row increments when `pi_flag` is high and cnt_col==CNT_COL_MAX; it wraps from CNT_ROW_MAX to 0.
- The sof and eol tags are computed at stage 1 from the counter values before the increment. They travel through the pipeline beside v1/v2.
- `pi_vsync` forces cnt_col=0 and cnt_row=0 on the next edge.
- If `pi_vsync` and `pi_flag` are high in the same cycle, that pixel is treated as (0,0): it is tagged sof, and the counters become col=1, row=0.
- A short frame (vsync arriving before the end) simply restarts the count.
- A long frame wraps the count with no error indication.

## Timing
- Latency: a pixel on `pi_flag` at cycle N appears on `po_flag`/`po_data` at N+3.
- Throughput: one pixel per clock. Gaps in `pi_flag` are preserved exactly at the output.
- `po_sof`/`po_eol` are cycle-aligned with `po_flag`. They are never high while `po_flag` is low.
- Reset values: po_data=0, po_flag=0, po_sof=0, po_eol=0, all v*/tags=0, cnt_col=0, cnt_row=0.
- Reset mid-frame: pixels in flight are discarded. No `po_flag` fires in the cycle after reset deasserts unless a new pixel arrived 3 cycles earlier. Counters restart at (0,0).

## Configuration
- RGB2GRAY_FRAME_MARK_EN defined:
  - cnt_col, cnt_row, the sof/eol tag pipeline and `pi_vsync` handling are built as described above.
- RGB2GRAY_FRAME_MARK_EN undefined:
  - no counters are built and `pi_vsync` is ignored;
  - `po_sof` and `po_eol` are tied to 0;
  - the pixel datapath and its latency are identical in both builds.

## Structure
- Shared ISP package holds:
  - luma coefficients COEF_R=77, COEF_G=150, COEF_B=29;
  - the RGB565 field positions;
  - the gray width (8).
- One sub-module, `rgb565_expand`: purely combinational 5/6-bit to 8-bit replication, instantiated in stage 1.
- Counters and the pipeline stay in the top module.

## Test plan
- White `16'hFFFF`, then black `16'h0000`, back-to-back → `po_data` 255 then 0, at cycles N+3 and N+4.
- Pure red `F800`, green `07E0`, blue `001F` → 76, 149, 28.
- `pi_flag` pattern 1,0,0,1,1 → `po_flag` shows the same pattern delayed by exactly 3 cycles; `po_data` holds its value during the gaps.
- With the macro defined and a 100×100 frame:
  - `po_sof` occurs once, on the first output;
  - `po_eol` occurs every 100th `po_flag`;
  - pixel 10000 wraps back to (0,0);
  - a `pi_vsync` issued after 250 pixels makes the next pixel sof.
- `sys_rst` asserted with 2 pixels in flight → no `po_flag` for those pixels; all outputs 0; counters 0.
- Macro undefined → `po_sof`/`po_eol` stay 0 through the whole frame, including `pi_vsync` pulses.
